// File: rtl/booth_pkg.sv
// Shared constants, FSM state encoding and radix-4 Booth group codes for the
// sequential Booth multiplier and its partial-product decoder.
package booth_pkg;

  localparam int OP_W     = 16;
  localparam int PP_W     = 17;
  localparam int PROD_W   = 32;
  localparam int N_GROUPS = 8;
  localparam int CNT_W    = $clog2(N_GROUPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CODE_ZERO_P = 3'b000;
  localparam logic [2:0] CODE_PA1    = 3'b001;
  localparam logic [2:0] CODE_PA2    = 3'b010;
  localparam logic [2:0] CODE_P2A    = 3'b011;
  localparam logic [2:0] CODE_M2A    = 3'b100;
  localparam logic [2:0] CODE_MA1    = 3'b101;
  localparam logic [2:0] CODE_MA2    = 3'b110;
  localparam logic [2:0] CODE_ZERO_N = 3'b111;

endpackage

// File: rtl/booth2_pp_decoder.sv
// Radix-4 Booth partial-product selector: maps a 3-bit group code onto
// 0, +A, +2A, -2A or -A as a 17-bit two's-complement value.
module booth2_pp_decoder
  import booth_pkg::*;
(
  input  logic [2:0]      i_code,
  input  logic [OP_W-1:0] i_a,
  input  logic [OP_W-1:0] i_neg_a,
  output logic [PP_W-1:0] o_pp
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    o_pp = '0;
    case (i_code)
      CODE_PA1, CODE_PA2: o_pp = {i_a[OP_W-1], i_a};
      CODE_P2A:           o_pp = {i_a, 1'b0};
      CODE_M2A:           o_pp = {i_neg_a, 1'b0};
      CODE_MA1, CODE_MA2: o_pp = {i_neg_a[OP_W-1], i_neg_a};
      default:            o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth4_seq_mult_ctrl.sv
// Iterative 16x16 signed radix-4 Booth multiplier: one group code per cycle
// through a shared decoder, accumulated into a 32-bit product.
module booth4_seq_mult_ctrl
  import booth_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] P,
  output logic              busy,
  input  logic              abort
);

  state_t              r_state, w_next;
  logic [OP_W-1:0]     r_a, r_neg_a;
  logic [PP_W-1:0]     r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_acc;
  logic [PP_W-1:0]     w_dec_pp;
  logic [PP_W:0]       w_pp;
  logic [PP_W-1:0]     w_b_shifted;
  logic [PROD_W-1:0]   w_pp_shifted;
  logic                w_accept;
  logic                w_last;

  booth2_pp_decoder u_dec (
    .i_code  (r_b[2:0]),
    .i_a     (r_a),
    .i_neg_a (r_neg_a),
    .o_pp    (w_dec_pp)
  );

  assign w_accept    = in_valid && (r_state == IDLE) && !abort;
  assign w_b_shifted = {{2{r_b[PP_W-1]}}, r_b[PP_W-1:2]};
  assign w_last      = (r_cnt == CNT_W'(N_GROUPS - 1)) ||
                       (EARLY_TERM && ((w_b_shifted == '0) || (&w_b_shifted)));

  // For A = -32768 the 16-bit negA wraps to itself, so +-A and +-2A need 18-bit substitutes.
  always_comb begin
    w_pp = {w_dec_pp[PP_W-1], w_dec_pp};
    if (r_a == 16'h8000) begin
      case (r_b[2:0])
        CODE_P2A:           w_pp = 18'h30000;
        CODE_M2A:           w_pp = 18'h10000;
        CODE_PA1, CODE_PA2: w_pp = 18'h38000;
        CODE_MA1, CODE_MA2: w_pp = 18'h08000;
        default:            w_pp = 18'h00000;
      endcase
    end
  end

  assign w_pp_shifted = {{(PROD_W-PP_W-1){w_pp[PP_W]}}, w_pp} << {r_cnt, 1'b0};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = (r_state == IDLE);
    busy      = (r_state == RUN);
    out_valid = (r_state == DONE);
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (abort) w_next = IDLE;
               else if (w_last) w_next = DONE;
      DONE:    if (abort || out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: operand registers are reset too; they are few flops, not a memory array.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_a     <= '0;
      r_neg_a <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (abort && (r_state != IDLE)) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_neg_a <= ~A + OP_W'(1);
      r_b     <= {B, 1'b0};
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == RUN) begin
      r_acc <= r_acc + w_pp_shifted;
      r_b   <= w_b_shifted;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign P = r_acc;

endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
// Scoreboard bench: one instance without and one with early termination,
// directed corner cases plus random signed operand pairs.
module tb_booth4_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        abort_i, out_ready_i;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [31:0] p0, p1;

  logic [31:0] sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  booth4_seq_mult_ctrl #(.EARLY_TERM(1'b0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .A(a), .B(b), .out_valid(out_valid0), .out_ready(out_ready_i), .P(p0),
    .busy(busy0), .abort(abort_i)
  );

  booth4_seq_mult_ctrl #(.EARLY_TERM(1'b1)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a), .B(b), .out_valid(out_valid1), .out_ready(out_ready_i), .P(p1),
    .busy(busy1), .abort(abort_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_p(input bit sel);
    return sel ? p1 : p0;
  endfunction
  function automatic logic [31:0] f_ov(input bit sel);
    return 32'(sel ? out_valid1 : out_valid0);
  endfunction
  function automatic logic [31:0] f_ir(input bit sel);
    return 32'(sel ? in_ready1 : in_ready0);
  endfunction
  function automatic logic [31:0] f_busy(input bit sel);
    return 32'(sel ? busy1 : busy0);
  endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) in_valid1 = v;
    else     in_valid0 = v;
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 32'(sx * sy);
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // exp_lat < 0 skips the latency check; hold = cycles of out_ready backpressure.
  task automatic run_op(input bit sel, input logic [15:0] ai, input logic [15:0] bi,
                        input int exp_lat, input int hold, input string tag);
    int          lat;
    logic [31:0] exp;
    @(negedge clk);
    a = ai;
    b = bi;
    set_valid(sel, 1'b1);
    if (exp_lat >= 0) check({tag, "_in_ready"}, f_ir(sel), 32'd1);
    @(posedge clk);
    sb_q.push_back(ref_mul(ai, bi));
    @(negedge clk);
    set_valid(sel, 1'b0);
    lat = 0;
    while (f_ov(sel) == 32'd0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (f_ov(sel) == 32'd0) check({tag, "_timeout"}, f_ov(sel), 32'd1);
    exp = sb_q.pop_front();
    check({tag, "_P"}, f_p(sel), exp);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_ov"}, f_ov(sel), 32'd1);
      check({tag, "_hold_P"}, f_p(sel), exp);
      check({tag, "_hold_in_ready"}, f_ir(sel), 32'd0);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    if (exp_lat >= 0) begin
      check({tag, "_idle_in_ready"}, f_ir(sel), 32'd1);
      check({tag, "_idle_ov"}, f_ov(sel), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_ov;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    abort_i = 1'b0;
    out_ready_i = 1'b0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      check("reset_in_ready", f_ir(s[0]), 32'd1);
      check("reset_ov", f_ov(s[0]), 32'd0);
      check("reset_busy", f_busy(s[0]), 32'd0);
      check("reset_P", f_p(s[0]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 16'd3, 16'd5, 8, 0, "small");
    check("small_P_const", p0, 32'h0000000F);
    run_op(1'b0, 16'h8000, 16'h8000, 8, 0, "min_min");
    check("min_min_const", p0, 32'h40000000);
    run_op(1'b0, 16'h8000, 16'h7FFF, 8, 0, "min_max");
    check("min_max_const", p0, 32'hC0008000);
    run_op(1'b1, 16'd1234, 16'd1, 1, 0, "et_pos");
    check("et_pos_const", p1, 32'd1234);
    run_op(1'b1, 16'd1234, 16'hFFFF, 1, 0, "et_neg");
    check("et_neg_const", p1, 32'hFFFFFB2E);
    run_op(1'b0, 16'hFFF9, 16'd9, 8, 20, "backpressure");
    check("backpressure_const", p0, 32'hFFFFFFC1);

    // Abort on the fourth RUN cycle.
    @(negedge clk);
    a = 16'd300;
    b = 16'd77;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy0), 32'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_in_ready", 32'(in_ready0), 32'd1);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_P", p0, 32'd0);
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_ov = seen_ov | out_valid0;
    end
    check("abort_no_ov", 32'(seen_ov), 32'd0);
    run_op(1'b0, 16'd100, 16'hFF9C, 8, 0, "post_abort");
    check("post_abort_const", p0, 32'hFFFFD8F0);

    // Abort in IDLE swallows a simultaneous in_valid.
    @(negedge clk);
    a = 16'd5;
    b = 16'd5;
    in_valid1 = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    abort_i = 1'b0;
    check("idle_abort_busy", 32'(busy1), 32'd0);
    check("idle_abort_in_ready", 32'(in_ready1), 32'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h5678;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready0), 32'd1);
    check("midrst_ov", 32'(out_valid0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_P", p0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++)
      run_op(i[0], rand16(), rand16(), -1, 0, "rand");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
